// File: rtl/pc_next_unit_if.sv
// Fetch-stage PC/RAS bus: redirect requests and RAS commands in; PC and RAS state out.
// The master is the control side that drives requests; the slave is pc_next_unit.
interface pc_next_unit_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic            stall;
  logic            redirect_valid;
  logic [1:0]      redirect_type;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] redirect_imm;
  logic [XLEN-1:0] redirect_rs1;
  logic [XLEN-1:0] trap_vector;
  logic            ras_push;
  logic            ras_pop;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            misalign_err;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic [CW-1:0]   ras_count;

  modport master (
    output stall, redirect_valid, redirect_type, redirect_pc, redirect_imm,
           redirect_rs1, trap_vector, ras_push, ras_pop,
    input  pc, pc_plus, misalign_err, ras_top, ras_empty, ras_full, ras_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_type, redirect_pc, redirect_imm,
           redirect_rs1, trap_vector, ras_push, ras_pop,
    output pc, pc_plus, misalign_err, ras_top, ras_empty, ras_full, ras_count
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered fetch-PC generator with branch/JAL/JALR/trap redirects, alignment check,
// and a circular return-address stack for call/return prediction.
module pc_next_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter int unsigned     RAS_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst_n,
  pc_next_unit_if.slave bus
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    RD_BRANCH = 2'b00,
    RD_JAL    = 2'b01,
    RD_JALR   = 2'b10,
    RD_TRAP   = 2'b11
  } redir_type_e;

  redir_type_e     rtype;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            is_trap;
  logic            misaligned;
  logic            take;
  logic            reject;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   tp_q, tp_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ras_wr_en;
  logic [PW-1:0]   ras_wr_idx;
  logic [XLEN-1:0] push_ret;
  logic            ras_is_empty;
  logic            ras_is_full;

  assign rtype    = redir_type_e'(bus.redirect_type);
  assign jalr_sum = bus.redirect_rs1 + bus.redirect_imm;

  always_comb begin
    target  = '0;
    is_trap = 1'b0;
    case (rtype)
      RD_BRANCH, RD_JAL: target = bus.redirect_pc + bus.redirect_imm;
      RD_JALR:           target = jalr_sum & ~XLEN'(1);
      default: begin
        target  = bus.trap_vector;
        is_trap = 1'b1;
      end
    endcase
  end

  // Trap targets bypass the alignment check and are loaded verbatim.
  assign misaligned = !is_trap && (INSTR_BYTES == 4) && target[1];
  assign take       = bus.redirect_valid && !misaligned;
  assign reject     = bus.redirect_valid && misaligned;

  always_comb begin
    pc_d  = pc_q + XLEN'(INSTR_BYTES);
    err_d = reject;
    if (take) begin
      pc_d = target;
    end else if (bus.stall || reject) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign ras_is_empty = (count_q == '0);
  assign ras_is_full  = (count_q == CW'(RAS_DEPTH));
  assign push_ret     = bus.redirect_pc + XLEN'(INSTR_BYTES);

  // Push+pop on a non-empty stack rewrites the top in place; on an empty one it is a push.
  always_comb begin
    tp_d       = tp_q;
    count_d    = count_q;
    ras_wr_en  = 1'b0;
    ras_wr_idx = tp_q;
    if (bus.ras_push && bus.ras_pop && !ras_is_empty) begin
      ras_wr_en = 1'b1;
    end else if (bus.ras_push) begin
      tp_d       = tp_q + PW'(1);
      ras_wr_idx = tp_q + PW'(1);
      ras_wr_en  = 1'b1;
      if (!ras_is_full) begin
        count_d = count_q + CW'(1);
      end
    end else if (bus.ras_pop && !ras_is_empty) begin
      tp_d    = tp_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q    <= '0;
      count_q <= '0;
    end else begin
      tp_q    <= tp_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_wr_en) begin
      ras_mem[ras_wr_idx] <= push_ret;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus      = pc_q + XLEN'(INSTR_BYTES);
  assign bus.misalign_err = err_q;
  assign bus.ras_top      = ras_is_empty ? '0 : ras_mem[tp_q];
  assign bus.ras_empty    = ras_is_empty;
  assign bus.ras_full     = ras_is_full;
  assign bus.ras_count    = count_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed-vector bench for pc_next_unit with RESET_PC = 0x100 and RAS_DEPTH = 4.
module tb_pc_next_unit;
  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;

  pc_next_unit_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_next_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0100),
    .INSTR_BYTES(4),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_type  = 2'b00;
    bus.redirect_pc    = '0;
    bus.redirect_imm   = '0;
    bus.redirect_rs1   = '0;
    bus.trap_vector    = '0;
    bus.ras_push       = 1'b0;
    bus.ras_pop        = 1'b0;
  endtask

  task automatic redirect(input logic [1:0] t, input logic [31:0] rpc, input logic [31:0] imm,
                          input logic [31:0] rs1, input logic [31:0] tv);
    bus.redirect_valid = 1'b1;
    bus.redirect_type  = t;
    bus.redirect_pc    = rpc;
    bus.redirect_imm   = imm;
    bus.redirect_rs1   = rs1;
    bus.trap_vector    = tv;
  endtask

  task automatic ras_op(input logic push, input logic pop, input logic [31:0] rpc);
    bus.ras_push    = push;
    bus.ras_pop     = pop;
    bus.redirect_pc = rpc;
    step();
    bus.ras_push = 1'b0;
    bus.ras_pop  = 1'b0;
  endtask

  logic [31:0] exp_pc;
  logic [31:0] push_tops [5];
  logic [31:0] pop_tops [4];

  initial begin
    checks = 0;
    errors = 0;
    push_tops = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    pop_tops  = '{32'h40, 32'h30, 32'h20, 32'h0};
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    check_eq("rst_pc", bus.pc, 32'h100);
    check_eq("rst_err", {31'd0, bus.misalign_err}, 32'd0);
    check_eq("rst_empty", {31'd0, bus.ras_empty}, 32'd1);
    check_eq("rst_full", {31'd0, bus.ras_full}, 32'd0);
    check_eq("rst_top", bus.ras_top, 32'd0);
    check_eq("rst_count", {29'd0, bus.ras_count}, 32'd0);
    check_eq("rst_pc_plus", bus.pc_plus, 32'h104);

    rst_n = 1'b1;
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      check_eq("inc_pc", bus.pc, exp_pc);
      check_eq("inc_pc_plus", bus.pc_plus, exp_pc + 32'd4);
    end

    redirect(2'b00, 32'h200, 32'hFFFF_FFF0, 32'h0, 32'h0);
    step();
    check_eq("branch_neg", bus.pc, 32'h1F0);
    check_eq("branch_err", {31'd0, bus.misalign_err}, 32'd0);
    redirect(2'b01, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0);
    step();
    check_eq("jal_wrap", bus.pc, 32'h4);
    redirect(2'b10, 32'h0, 32'h3, 32'h301, 32'h0);
    step();
    check_eq("jalr_lsb", bus.pc, 32'h304);
    redirect(2'b10, 32'h0, 32'h2, 32'h300, 32'h0);
    step();
    check_eq("misalign_hold", bus.pc, 32'h304);
    check_eq("misalign_pulse", {31'd0, bus.misalign_err}, 32'd1);
    clear_inputs();
    step();
    check_eq("misalign_drop", {31'd0, bus.misalign_err}, 32'd0);
    check_eq("after_misalign_pc", bus.pc, 32'h308);
    redirect(2'b11, 32'h0, 32'h0, 32'h0, 32'h8000_0002);
    step();
    check_eq("trap_pc", bus.pc, 32'h8000_0002);
    check_eq("trap_err", {31'd0, bus.misalign_err}, 32'd0);

    clear_inputs();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_hold", bus.pc, 32'h8000_0002);
    end
    redirect(2'b00, 32'h3F0, 32'h10, 32'h0, 32'h0);
    step();
    check_eq("stall_redirect", bus.pc, 32'h400);
    clear_inputs();

    for (int i = 0; i < 5; i++) begin
      ras_op(1'b1, 1'b0, push_tops[i] - 32'd4);
      check_eq("push_top", bus.ras_top, push_tops[i]);
    end
    check_eq("ovf_full", {31'd0, bus.ras_full}, 32'd1);
    check_eq("ovf_count", {29'd0, bus.ras_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      ras_op(1'b0, 1'b1, 32'h0);
      check_eq("pop_top", bus.ras_top, pop_tops[i]);
    end
    check_eq("pop_empty", {31'd0, bus.ras_empty}, 32'd1);
    ras_op(1'b0, 1'b1, 32'h0);
    check_eq("underflow_top", bus.ras_top, 32'd0);
    check_eq("underflow_count", {29'd0, bus.ras_count}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      ras_op(1'b1, 1'b0, push_tops[i] - 32'd4);
    end
    check_eq("pre_pp_top", bus.ras_top, 32'h30);
    ras_op(1'b1, 1'b1, 32'h7C);
    check_eq("pp_top", bus.ras_top, 32'h80);
    check_eq("pp_count", {29'd0, bus.ras_count}, 32'd3);
    ras_op(1'b0, 1'b1, 32'h0);
    check_eq("pp_below", bus.ras_top, 32'h20);
    ras_op(1'b1, 1'b0, 32'h2C);
    check_eq("repush_count", {29'd0, bus.ras_count}, 32'd3);

    bus.stall = 1'b1;
    redirect(2'b00, 32'h200, 32'hFFFF_FFF0, 32'h0, 32'h0);
    step();
    check_eq("pre_rst_pc", bus.pc, 32'h1F0);
    redirect(2'b10, 32'h0, 32'h2, 32'h300, 32'h0);
    step();
    check_eq("pre_rst_err", {31'd0, bus.misalign_err}, 32'd1);
    check_eq("pre_rst_hold", bus.pc, 32'h1F0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_pc", bus.pc, 32'h100);
    check_eq("async_empty", {31'd0, bus.ras_empty}, 32'd1);
    check_eq("async_err", {31'd0, bus.misalign_err}, 32'd0);
    check_eq("async_top", bus.ras_top, 32'd0);
    check_eq("async_count", {29'd0, bus.ras_count}, 32'd0);
    step();
    check_eq("held_rst_pc", bus.pc, 32'h100);
    clear_inputs();
    rst_n = 1'b1;

    ras_op(1'b1, 1'b1, 32'h1C);
    check_eq("pp_empty_count", {29'd0, bus.ras_count}, 32'd1);
    check_eq("pp_empty_top", bus.ras_top, 32'h20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter generation unit for the fetch stage. It holds the architectural fetch PC and advances it sequentially. It computes branch (PC + immediate), JAL, JALR and trap redirect targets, with alignment checking. A circular return-address stack (RAS) feeds call/return prediction. It replaces the purely combinational PC + branch-offset adder with a registered, stall-aware next-PC path.

## Interface
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- INSTR_BYTES, 4, sequential increment and return-address offset.
- RAS_DEPTH, 4, RAS entries; power of two, ≥2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold PC when no redirect is active.
- redirect_valid  in  1  control-flow redirect request this cycle.
- redirect_type  in  2  00 branch-taken, 01 JAL, 10 JALR, 11 trap.
- redirect_pc  in  XLEN  address of the redirecting instruction.
- redirect_imm  in  XLEN  sign-extended immediate (B/J/I-type).
- redirect_rs1  in  XLEN  rs1 operand for JALR.
- trap_vector  in  XLEN  trap handler address.
- ras_push  in  1  push redirect_pc + INSTR_BYTES.
- ras_pop  in  1  pop top entry.
- pc  out  XLEN  registered current fetch PC.
- pc_plus  out  XLEN  combinational pc + INSTR_BYTES.
- misalign_err  out  1  registered one-cycle pulse: rejected misaligned target.
- ras_top  out  XLEN  combinational top-of-stack value, 0 when empty.
- ras_empty  out  1  count == 0.
- ras_full  out  1  count == RAS_DEPTH.
- ras_count  out  clog2(RAS_DEPTH)+1  valid entries.

## Operation
- Target computation (all XLEN-bit, modulo 2^XLEN, carries discarded):
  - Branch and JAL: redirect_pc + redirect_imm.
  - JALR: (redirect_rs1 + redirect_imm) & ~1.
  - Trap: trap_vector.
- Misalignment: applies to non-trap targets whose bit[1] is set while INSTR_BYTES == 4.
  - PC holds its value.
  - misalign_err = 1 for the next cycle.
  - No redirect occurs.
  - A trap target is never checked; it is loaded as-is.
- Next-PC priority per edge:
  1. redirect_valid with an aligned target (or trap) loads the target. This overrides stall.
  2. Otherwise, stall holds pc.
  3. Otherwise, pc advances to pc + INSTR_BYTES.
- RAS: circular buffer with top pointer tp and count.
  - Push: writes at tp+1 (mod RAS_DEPTH) and advances tp. The count increments, saturating at RAS_DEPTH. A push while full overwrites the oldest entry.
  - Pop: decrements tp and count. A pop while empty is ignored.
  - Push and pop in the same cycle: replaces the top entry; tp and count are unchanged. If the stack is empty, this behaves as a push.
  - RAS operations are independent of stall and redirect_valid.
- Reset (asserted at any time, including mid-redirect): pc = RESET_PC, misalign_err = 0, count = 0, tp = 0. ras_top reads 0, ras_empty = 1, ras_full = 0. RAS storage is not cleared.

## Timing
- Redirect sampled at edge N: pc equals the target after edge N. Latency is 1 cycle, with no bubble inserted internally.
- Misalign rejected at edge N: misalign_err is high from edge N to edge N+1 only.
- pc_plus, ras_top and the RAS flags follow register state combinationally, within the same cycle.
- A push at edge N is visible on ras_top after edge N.
- Reset takes effect immediately on rst_n falling. The first update occurs at the first rising clk with rst_n high.

## Test plan
- Reset and increment:
  - Stimulus: RESET_PC = 0x100, release rst_n, 3 idle cycles.
  - Required response: pc = 0x100, 0x104, 0x108, 0x10C; pc_plus = pc + 4.
- Branch and JAL with negative offset and wrap-around:
  - Stimulus: redirect_pc = 0x200, imm = 0xFFFF_FFF0, type 00.
  - Required response: pc = 0x1F0 next cycle.
  - Stimulus: redirect_pc = 0xFFFF_FFFC, imm = 8, type 01.
  - Required response: pc = 0x4.
- JALR, alignment and trap:
  - Stimulus: rs1 = 0x301, imm = 0x3, type 10.
  - Required response: pc = 0x304.
  - Stimulus: rs1 = 0x300, imm = 0x2, type 10.
  - Required response: pc held, misalign_err pulses for 1 cycle.
  - Stimulus: type 11, trap_vector = 0x8000_0002.
  - Required response: pc = 0x8000_0002, no error.
- Stall versus redirect:
  - Stimulus: stall = 1 for 3 cycles.
  - Required response: pc constant.
  - Stimulus: stall = 1 with a simultaneous branch to 0x400.
  - Required response: pc = 0x400.
- RAS overflow, underflow and simultaneous operations (RAS_DEPTH = 4):
  - Stimulus: push return addresses 0x10, 0x20, 0x30, 0x40, 0x50.
  - Required response: ras_full = 1, count = 4, ras_top = 0x50.
  - Stimulus: pop 4 times.
  - Required response: tops read 0x40, 0x30, 0x20, then empty.
  - Stimulus: a 5th pop.
  - Required response: ignored, ras_top = 0.
  - Stimulus: push and pop together on a top of 0x30.
  - Required response: top = new value, count unchanged.
- Asynchronous reset mid-operation:
  - Stimulus: drop rst_n between edges, with count = 3 and pc = 0x1F0.
  - Required response: immediately pc = RESET_PC, ras_empty = 1, misalign_err = 0.
